// File: rtl/csr_pkg.sv
// Shared encodings for the CSR access unit: funct3 op codes, trap causes,
// privilege levels and the sequencing FSM state type.
package csr_pkg;

  localparam logic [2:0] Funct3Csrrw  = 3'b001;
  localparam logic [2:0] Funct3Csrrs  = 3'b010;
  localparam logic [2:0] Funct3Csrrc  = 3'b011;
  localparam logic [2:0] Funct3Csrrwi = 3'b101;
  localparam logic [2:0] Funct3Csrrsi = 3'b110;
  localparam logic [2:0] Funct3Csrrci = 3'b111;

  localparam int unsigned CauseIllegalInst = 2;

  localparam logic [1:0] PrivU = 2'b00;
  localparam logic [1:0] PrivS = 2'b01;
  localparam logic [1:0] PrivM = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWrite,
    StTrap,
    StMret
  } csr_state_e;

endpackage

// File: rtl/csr_alu.sv
// Combinational CSR op decode: write-needed, legality check and the
// read-modify-write result for CSRRW/S/C and their immediate forms.
module csr_alu
  import csr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3,
  input  logic [11:0]           csr_addr,
  input  logic [4:0]            rs1_idx,
  input  logic [DATA_WIDTH-1:0] rs1_val,
  input  logic                  is_mret,
  input  logic [1:0]            priv,
  input  logic [DATA_WIDTH-1:0] old_val,
  output logic                  wr_needed,
  output logic                  illegal,
  output logic [DATA_WIDTH-1:0] new_val
);

  logic [DATA_WIDTH-1:0] src;

  always_comb begin
    // funct3[2] selects the zero-extended rs1 index (zimm) form
    src = funct3[2] ? {{(DATA_WIDTH-5){1'b0}}, rs1_idx} : rs1_val;

    wr_needed = 1'b0;
    new_val   = old_val;
    case (funct3[1:0])
      Funct3Csrrw[1:0]: begin
        wr_needed = 1'b1;
        new_val   = src;
      end
      Funct3Csrrs[1:0]: begin
        wr_needed = (rs1_idx != 5'd0);
        new_val   = old_val | src;
      end
      Funct3Csrrc[1:0]: begin
        wr_needed = (rs1_idx != 5'd0);
        new_val   = old_val & ~src;
      end
      default: begin
        wr_needed = 1'b0;
        new_val   = old_val;
      end
    endcase

    if (is_mret) begin
      illegal = (priv != PrivM);
    end else begin
      illegal = (funct3[1:0] == 2'b00)
             || (priv < csr_addr[9:8])
             || (wr_needed && (csr_addr[11:10] == 2'b11));
    end
  end

endmodule

// File: rtl/csr_access_unit.sv
// Sequences one CSR instruction at a time: read, read-modify-write, illegal
// instruction trap or MRET, with all pulse outputs registered.
module csr_access_unit
  import csr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ILLEGAL_CAUSE = CauseIllegalInst
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_funct3,
  input  logic [11:0]           req_csr_addr,
  input  logic [DATA_WIDTH-1:0] req_rs1_val,
  input  logic [4:0]            req_rs1_idx,
  input  logic                  req_is_mret,
  input  logic [1:0]            req_priv,
  input  logic [DATA_WIDTH-1:0] req_pc,
  input  logic [31:0]           req_inst,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_illegal,
  output logic [11:0]           csr_raddr,
  input  logic [DATA_WIDTH-1:0] csr_rdata,
  output logic                  csr_wen,
  output logic [11:0]           csr_waddr,
  output logic [DATA_WIDTH-1:0] csr_wdata,
  output logic                  exception_commit,
  output logic [DATA_WIDTH-1:0] exception_pc,
  output logic [DATA_WIDTH-1:0] exception_cause,
  output logic [DATA_WIDTH-1:0] exception_tval,
  output logic                  mret_commit,
  output logic [1:0]            priv_level,
  input  logic [DATA_WIDTH-1:0] handler_addr,
  input  logic [DATA_WIDTH-1:0] mret_out,
  output logic                  redirect_valid,
  output logic [DATA_WIDTH-1:0] redirect_pc
);

  csr_state_e            state_q;
  logic [2:0]            funct3_q;
  logic [11:0]           addr_q;
  logic [DATA_WIDTH-1:0] rs1_val_q;
  logic [4:0]            rs1_idx_q;
  logic                  is_mret_q;
  logic [1:0]            priv_q;

  logic                  in_idle;
  logic [2:0]            alu_funct3;
  logic [11:0]           alu_addr;
  logic [DATA_WIDTH-1:0] alu_rs1_val;
  logic [4:0]            alu_rs1_idx;
  logic                  alu_is_mret;
  logic [1:0]            alu_priv;
  logic                  wr_needed;
  logic                  illegal;
  logic [DATA_WIDTH-1:0] new_val;

  assign in_idle   = (state_q == StIdle);
  assign req_ready = in_idle;
  assign csr_raddr = addr_q;

  // One ALU serves both phases: legality on the live request in IDLE,
  // RMW on the captured request in READ.
  assign alu_funct3  = in_idle ? req_funct3   : funct3_q;
  assign alu_addr    = in_idle ? req_csr_addr : addr_q;
  assign alu_rs1_val = in_idle ? req_rs1_val  : rs1_val_q;
  assign alu_rs1_idx = in_idle ? req_rs1_idx  : rs1_idx_q;
  assign alu_is_mret = in_idle ? req_is_mret  : is_mret_q;
  assign alu_priv    = in_idle ? req_priv     : priv_q;

  csr_alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_csr_alu (
    .funct3   (alu_funct3),
    .csr_addr (alu_addr),
    .rs1_idx  (alu_rs1_idx),
    .rs1_val  (alu_rs1_val),
    .is_mret  (alu_is_mret),
    .priv     (alu_priv),
    .old_val  (csr_rdata),
    .wr_needed(wr_needed),
    .illegal  (illegal),
    .new_val  (new_val)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= StIdle;
      funct3_q         <= '0;
      addr_q           <= '0;
      rs1_val_q        <= '0;
      rs1_idx_q        <= '0;
      is_mret_q        <= 1'b0;
      priv_q           <= '0;
      priv_level       <= PrivM;
      rsp_valid        <= 1'b0;
      rsp_rdata        <= '0;
      rsp_illegal      <= 1'b0;
      csr_wen          <= 1'b0;
      csr_waddr        <= '0;
      csr_wdata        <= '0;
      exception_commit <= 1'b0;
      exception_pc     <= '0;
      exception_cause  <= '0;
      exception_tval   <= '0;
      mret_commit      <= 1'b0;
      redirect_valid   <= 1'b0;
      redirect_pc      <= '0;
    end else begin
      // Every output is a single-cycle pulse; clear by default
      rsp_valid        <= 1'b0;
      rsp_rdata        <= '0;
      rsp_illegal      <= 1'b0;
      csr_wen          <= 1'b0;
      csr_waddr        <= '0;
      csr_wdata        <= '0;
      exception_commit <= 1'b0;
      exception_pc     <= '0;
      exception_cause  <= '0;
      exception_tval   <= '0;
      mret_commit      <= 1'b0;
      redirect_valid   <= 1'b0;
      redirect_pc      <= '0;

      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            funct3_q  <= req_funct3;
            addr_q    <= req_csr_addr;
            rs1_val_q <= req_rs1_val;
            rs1_idx_q <= req_rs1_idx;
            is_mret_q <= req_is_mret;
            priv_q    <= req_priv;
            if (req_is_mret && (req_priv == PrivM)) begin
              state_q        <= StMret;
              mret_commit    <= 1'b1;
              redirect_valid <= 1'b1;
              redirect_pc    <= mret_out;
              rsp_valid      <= 1'b1;
            end else if (illegal) begin
              state_q          <= StTrap;
              exception_commit <= 1'b1;
              exception_pc     <= req_pc;
              exception_cause  <= DATA_WIDTH'(ILLEGAL_CAUSE);
              exception_tval   <= DATA_WIDTH'(req_inst);
              redirect_valid   <= 1'b1;
              redirect_pc      <= handler_addr;
              rsp_valid        <= 1'b1;
              rsp_illegal      <= 1'b1;
            end else begin
              state_q <= StRead;
            end
          end
        end
        StRead: begin
          state_q   <= StWrite;
          csr_wen   <= wr_needed;
          csr_waddr <= addr_q;
          csr_wdata <= new_val;
          rsp_valid <= 1'b1;
          rsp_rdata <= csr_rdata;
        end
        StWrite: begin
          state_q <= StIdle;
        end
        StTrap: begin
          state_q    <= StIdle;
          priv_level <= PrivM;
        end
        StMret: begin
          state_q    <= StIdle;
          priv_level <= PrivU;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed bench for csr_access_unit: RMW ops, traps, MRET and mid-op reset.
module tb_csr_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [11:0] req_csr_addr;
  logic [31:0] req_rs1_val;
  logic [4:0]  req_rs1_idx;
  logic        req_is_mret;
  logic [1:0]  req_priv;
  logic [31:0] req_pc;
  logic [31:0] req_inst;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_illegal;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        csr_wen;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        exception_commit;
  logic [31:0] exception_pc;
  logic [31:0] exception_cause;
  logic [31:0] exception_tval;
  logic        mret_commit;
  logic [1:0]  priv_level;
  logic [31:0] handler_addr;
  logic [31:0] mret_out;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  csr_access_unit #(
    .DATA_WIDTH   (32),
    .ILLEGAL_CAUSE(2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_funct3      (req_funct3),
    .req_csr_addr    (req_csr_addr),
    .req_rs1_val     (req_rs1_val),
    .req_rs1_idx     (req_rs1_idx),
    .req_is_mret     (req_is_mret),
    .req_priv        (req_priv),
    .req_pc          (req_pc),
    .req_inst        (req_inst),
    .rsp_valid       (rsp_valid),
    .rsp_rdata       (rsp_rdata),
    .rsp_illegal     (rsp_illegal),
    .csr_raddr       (csr_raddr),
    .csr_rdata       (csr_rdata),
    .csr_wen         (csr_wen),
    .csr_waddr       (csr_waddr),
    .csr_wdata       (csr_wdata),
    .exception_commit(exception_commit),
    .exception_pc    (exception_pc),
    .exception_cause (exception_cause),
    .exception_tval  (exception_tval),
    .mret_commit     (mret_commit),
    .priv_level      (priv_level),
    .handler_addr    (handler_addr),
    .mret_out        (mret_out),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single accept edge, then scrambles the fields
  // so later phases must rely on the captured copy.
  task automatic issue(input logic [2:0] f3, input logic [11:0] addr, input logic [31:0] val,
                       input logic [4:0] idx, input logic mret, input logic [1:0] priv,
                       input logic [31:0] pc, input logic [31:0] inst);
    req_valid    = 1'b1;
    req_funct3   = f3;
    req_csr_addr = addr;
    req_rs1_val  = val;
    req_rs1_idx  = idx;
    req_is_mret  = mret;
    req_priv     = priv;
    req_pc       = pc;
    req_inst     = inst;
    step();
    req_valid    = 1'b0;
    req_funct3   = 3'b000;
    req_csr_addr = 12'h000;
    req_rs1_val  = 32'hDEAD_BEEF;
    req_rs1_idx  = 5'd31;
    req_is_mret  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_funct3   = 3'b000;
    req_csr_addr = 12'h000;
    req_rs1_val  = 32'h0;
    req_rs1_idx  = 5'd0;
    req_is_mret  = 1'b0;
    req_priv     = 2'd3;
    req_pc       = 32'h0;
    req_inst     = 32'h0;
    csr_rdata    = 32'h0;
    handler_addr = 32'h0000_0100;
    mret_out     = 32'h8000_1000;
    step();
    step();
    check("reset_ready", req_ready, 1);
    check("reset_priv", priv_level, 3);
    check("reset_wen", csr_wen, 0);
    check("reset_rsp", rsp_valid, 0);
    rst = 1'b0;

    // CSRRW 0x340, old 0
    csr_rdata = 32'h0;
    issue(3'b001, 12'h340, 32'hA5A5_A5A5, 5'd5, 1'b0, 2'd3, 32'h1000, 32'h3402_9073);
    check("rw_busy_ready", req_ready, 0);
    check("rw_raddr", csr_raddr, 32'h340);
    check("rw_wen_early", csr_wen, 0);
    step();
    check("rw_wen", csr_wen, 1);
    check("rw_waddr", csr_waddr, 32'h340);
    check("rw_wdata", csr_wdata, 32'hA5A5_A5A5);
    check("rw_rsp_valid", rsp_valid, 1);
    check("rw_rdata", rsp_rdata, 32'h0);
    check("rw_illegal", rsp_illegal, 0);
    step();
    check("rw_wen_done", csr_wen, 0);
    check("rw_ready_again", req_ready, 1);

    // CSRRS x0: read only
    csr_rdata = 32'h88;
    issue(3'b010, 12'h300, 32'hFFFF_FFFF, 5'd0, 1'b0, 2'd3, 32'h1004, 32'h3000_2073);
    check("rs0_no_trap", exception_commit, 0);
    step();
    check("rs0_wen", csr_wen, 0);
    check("rs0_rsp_valid", rsp_valid, 1);
    check("rs0_rdata", rsp_rdata, 32'h88);
    step();

    // CSRRCI zimm 8
    csr_rdata = 32'h888;
    issue(3'b111, 12'h304, 32'hFFFF_FFFF, 5'd8, 1'b0, 2'd3, 32'h1008, 32'h3044_7073);
    step();
    check("rci_wen", csr_wen, 1);
    check("rci_waddr", csr_waddr, 32'h304);
    check("rci_wdata", csr_wdata, 32'h880);
    check("rci_rdata", rsp_rdata, 32'h888);
    step();

    // CSRRS with register source
    csr_rdata = 32'h0000_00F0;
    issue(3'b010, 12'h340, 32'h0000_0F00, 5'd3, 1'b0, 2'd3, 32'h100C, 32'h3401_A073);
    step();
    check("rs_wen", csr_wen, 1);
    check("rs_wdata", csr_wdata, 32'h0000_0FF0);
    step();

    // CSRRW to read-only 0xF14 -> trap
    issue(3'b001, 12'hF14, 32'h1, 5'd1, 1'b0, 2'd3, 32'h2000, 32'hF140_9073);
    check("ro_exc", exception_commit, 1);
    check("ro_cause", exception_cause, 2);
    check("ro_pc", exception_pc, 32'h2000);
    check("ro_tval", exception_tval, 32'hF140_9073);
    check("ro_redir_valid", redirect_valid, 1);
    check("ro_redir_pc", redirect_pc, 32'h0000_0100);
    check("ro_rsp_valid", rsp_valid, 1);
    check("ro_rsp_illegal", rsp_illegal, 1);
    check("ro_rsp_rdata", rsp_rdata, 0);
    check("ro_wen", csr_wen, 0);
    check("ro_mret", mret_commit, 0);
    step();
    check("ro_exc_done", exception_commit, 0);
    check("ro_priv", priv_level, 3);
    check("ro_ready", req_ready, 1);
    step();
    check("ro_no_late_wen", csr_wen, 0);

    // CSRRS x0 on read-only CSR is legal
    csr_rdata = 32'h7;
    issue(3'b010, 12'hF14, 32'h0, 5'd0, 1'b0, 2'd3, 32'h2004, 32'hF140_2073);
    check("roread_no_trap", exception_commit, 0);
    step();
    check("roread_rdata", rsp_rdata, 32'h7);
    check("roread_wen", csr_wen, 0);
    step();

    // MRET at M-mode
    issue(3'b000, 12'h302, 32'h0, 5'd0, 1'b1, 2'd3, 32'h3000, 32'h3020_0073);
    check("mret_commit", mret_commit, 1);
    check("mret_redir_valid", redirect_valid, 1);
    check("mret_redir_pc", redirect_pc, 32'h8000_1000);
    check("mret_rsp_valid", rsp_valid, 1);
    check("mret_rsp_illegal", rsp_illegal, 0);
    check("mret_exc", exception_commit, 0);
    step();
    check("mret_priv", priv_level, 0);
    check("mret_ready", req_ready, 1);

    // MRET from U-mode -> trap
    issue(3'b000, 12'h302, 32'h0, 5'd0, 1'b1, 2'd0, 32'h3004, 32'h3020_0073);
    check("umret_exc", exception_commit, 1);
    check("umret_mret", mret_commit, 0);
    check("umret_tval", exception_tval, 32'h3020_0073);
    step();
    check("umret_priv", priv_level, 3);

    // M-level CSR from U-mode -> trap
    issue(3'b010, 12'h300, 32'h0, 5'd0, 1'b0, 2'd0, 32'h3008, 32'h3000_2073);
    check("upriv_exc", exception_commit, 1);
    step();

    // funct3 100 -> trap
    issue(3'b100, 12'h340, 32'h0, 5'd1, 1'b0, 2'd3, 32'h300C, 32'h3400_C073);
    check("f3_100_exc", exception_commit, 1);
    step();

    // Reset while in READ
    issue(3'b001, 12'h340, 32'h1234, 5'd2, 1'b0, 2'd3, 32'h4000, 32'h3401_1073);
    check("rst_busy", req_ready, 0);
    rst = 1'b1;
    step();
    check("rst_ready", req_ready, 1);
    check("rst_wen", csr_wen, 0);
    check("rst_rsp", rsp_valid, 0);
    rst = 1'b0;
    step();
    check("rst_no_late_wen", csr_wen, 0);
    check("rst_no_late_rsp", rsp_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/csr_access_unit.md
CSR_ACCESS_UNIT -- requirements
Module: csr_access_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, CSR data width.
REQ-002 SHALL have parameter ILLEGAL_CAUSE, default 2, mcause value for illegal instruction.
REQ-003 SHALL have one clock, clk, and reset rst; rst is synchronous and active-high.
REQ-004 SHALL have ports, in the form name direction width meaning:
- clk in 1 clock; rst in 1 sync active-high reset.
- req_valid in 1 request; req_ready out 1 accept.
- req_funct3 in 3 CSR op; req_csr_addr in 12; req_rs1_val in DATA_WIDTH; req_rs1_idx in 5 (also zimm); req_is_mret in 1.
- req_priv in 2 privilege; req_pc in DATA_WIDTH; req_inst in 32 raw instruction.
- rsp_valid out 1 pulse; rsp_rdata out DATA_WIDTH old CSR value; rsp_illegal out 1.
- csr_raddr out 12; csr_rdata in DATA_WIDTH.
- csr_wen out 1; csr_waddr out 12; csr_wdata out DATA_WIDTH.
- exception_commit out 1; exception_pc, exception_cause, exception_tval out DATA_WIDTH.
- mret_commit out 1; priv_level out 2.
- handler_addr in DATA_WIDTH (mtvec); mret_out in DATA_WIDTH (mepc).
- redirect_valid out 1 pulse; redirect_pc out DATA_WIDTH fetch redirect target.

Function
REQ-005 SHALL use FSM states IDLE, READ, WRITE, TRAP, MRET; req_ready=1 only in IDLE.
REQ-006 SHALL capture all req_* fields when req_valid&&req_ready; next state MRET if req_is_mret&&req_priv==3, TRAP if the request is illegal, else READ.
REQ-007 SHALL classify as illegal: funct3 000 or 100 without mret; req_is_mret with req_priv<3; req_priv<csr_addr[9:8]; write-needed with csr_addr[11:10]==2'b11.
REQ-008 SHALL treat req_is_mret as taking priority over funct3 decode.
REQ-009 SHALL deem write needed for CSRRW/CSRRWI always and for CSRRS/CSRRC/CSRRSI/CSRRCI only when req_rs1_idx!=0.
REQ-010 SHALL in READ drive csr_raddr=captured address and register csr_rdata at cycle end; next state WRITE.
REQ-011 SHALL form source = rs1_val (funct3[2]=0) or zero-extended rs1_idx (funct3[2]=1).
REQ-012 SHALL form new value as RW: src; RS: old|src; RC: old&~src.
REQ-013 SHALL in WRITE pulse csr_wen for one cycle only if write needed, with csr_waddr=address and csr_wdata=new value.
REQ-014 SHALL in WRITE also pulse rsp_valid with rsp_rdata=old value and rsp_illegal=0, then return to IDLE: accept-to-response latency 2 cycles.
REQ-015 SHALL in TRAP pulse exception_commit for one cycle with cause=ILLEGAL_CAUSE, pc=req_pc, tval=req_inst.
REQ-016 SHALL in the same TRAP cycle pulse redirect_valid with redirect_pc=handler_addr, and rsp_valid with rsp_illegal=1 and rsp_rdata=0.
REQ-017 SHALL leave TRAP for IDLE; priv_level becomes 3 on exit.
REQ-018 SHALL in MRET pulse mret_commit, redirect_valid (redirect_pc=mret_out) and rsp_valid (rsp_illegal=0, rsp_rdata=0) for one cycle.
REQ-019 SHALL leave MRET for IDLE; priv_level becomes 0 on exit.
REQ-020 SHALL never assert csr_wen, exception_commit or mret_commit in the same cycle as each other.
REQ-021 SHALL ignore req_valid in non-IDLE states; the requester must hold it.

Reset
REQ-022 SHALL on rst force IDLE and priv_level=3, and zero all pulse outputs and registered data, including mid-operation; no partial write completes.

Structure
REQ-023 SHALL take funct3 codes, cause codes, the FSM state enum and privilege encodings from shared package csr_pkg.
REQ-024 SHALL place RMW, write-needed and legality logic in a combinational sub-module csr_alu.

Verification
REQ-025 Bench SHALL check: CSRRW 0x340, rs1_val=0xA5A5A5A5, old 0x0 -> csr_wen two cycles after accept, wdata 0xA5A5A5A5, rsp_rdata 0x0.
REQ-026 Bench SHALL check: CSRRS 0x300, rs1_idx=0, old 0x88 -> no csr_wen, rsp_rdata 0x88.
REQ-027 Bench SHALL check: CSRRCI 0x304, zimm=0x8, old 0x888 -> wdata 0x880.
REQ-028 Bench SHALL check: CSRRW 0xF14 at priv 3 -> exception_commit, cause 2, tval=inst, redirect_pc=handler_addr, no csr_wen.
REQ-029 Bench SHALL check: MRET at priv 3, mret_out 0x80001000 -> mret_commit and redirect to 0x80001000; at priv 0 -> illegal trap.
REQ-030 Bench SHALL check: rst asserted in READ -> IDLE next cycle, no csr_wen, and req_ready=1.
